// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding and owner IDs.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;

  function automatic logic other_owner(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle and memory-port bundle for the arbiter.
interface dmem_req_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational picker: bit 0 = cpu, bit 1 = aux.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       cpu_prio,
  output logic       win_valid,
  output logic       win_id
);

  always_comb begin
    win_valid = |req;
    win_id    = OWN_CPU;
    case (req)
      2'b01:   win_id = OWN_CPU;
      2'b10:   win_id = OWN_AUX;
      // Conflict: fixed priority, or whoever did not go last.
      2'b11:   win_id = cpu_prio ? OWN_CPU : other_owner(last_owner);
      default: win_id = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port synchronous data memory between cpu and aux.
//   state | meaning
//   IDLE  | sample requests, register winner's access
//   ISSUE | access on memory port, winner's gnt high
//   RESP  | read data back from memory, owner's rvalid high
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_req_if.slave  cpu,
  dmem_req_if.slave  aux,
  dmem_mem_if.master mem,
  output logic       busy
);

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              last_owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic win_valid;
  logic win_id;

  logic mem_en_c;
  logic mem_we_c;
  logic cpu_gnt_c;
  logic aux_gnt_c;
  logic cpu_rv_c;
  logic aux_rv_c;

  rr_arb2 u_arb (
    .req        ({aux.req, cpu.req}),
    .last_owner (last_owner_q),
    .cpu_prio   (CPU_PRIO),
    .win_valid  (win_valid),
    .win_id     (win_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access is captured at the sample edge so the port is steady through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_AUX;
      last_owner_q <= OWN_AUX;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      if (state_q == IDLE && win_valid) begin
        owner_q <= win_id;
        we_q    <= (win_id == OWN_AUX) ? aux.we    : cpu.we;
        addr_q  <= (win_id == OWN_AUX) ? aux.addr  : cpu.addr;
        wdata_q <= (win_id == OWN_AUX) ? aux.wdata : cpu.wdata;
      end
      if (state_q == ISSUE) begin
        last_owner_q <= owner_q;
      end
    end
  end

  always_comb begin
    mem_en_c  = 1'b0;
    mem_we_c  = 1'b0;
    cpu_gnt_c = 1'b0;
    aux_gnt_c = 1'b0;
    cpu_rv_c  = 1'b0;
    aux_rv_c  = 1'b0;
    case (state_q)
      ISSUE: begin
        mem_en_c  = 1'b1;
        mem_we_c  = we_q;
        cpu_gnt_c = (owner_q == OWN_CPU);
        aux_gnt_c = (owner_q == OWN_AUX);
      end
      RESP: begin
        cpu_rv_c = (owner_q == OWN_CPU);
        aux_rv_c = (owner_q == OWN_AUX);
      end
      default: ;
    endcase
  end

  assign mem.en     = mem_en_c;
  assign mem.we     = mem_we_c;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;

  assign cpu.gnt    = cpu_gnt_c;
  assign aux.gnt    = aux_gnt_c;
  assign cpu.rvalid = cpu_rv_c;
  assign aux.rvalid = aux_rv_c;
  assign cpu.rdata  = cpu_rv_c ? mem.rdata : '0;
  assign aux.rdata  = aux_rv_c ? mem.rdata : '0;

  assign busy = (state_q != IDLE);

  a_one_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    !(cpu_gnt_c && aux_gnt_c));

  a_rv_after_read : assert property (@(posedge clk) disable iff (!rst_n)
    (cpu_rv_c || aux_rv_c) |-> $past(mem_en_c && !mem_we_c));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model; a second instance exercises cpu-priority mode.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic          gc;
    logic          ga;
    logic          rvc;
    logic          rva;
    logic          en;
    logic          we;
    logic          known;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) cpu0 ();
  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) aux0 ();
  dmem_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mb0 ();
  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) cpu1 ();
  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) aux1 ();
  dmem_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mb1 ();
  logic busy0;
  logic busy1;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu(cpu0), .aux(aux0), .mem(mb0), .busy(busy0));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu(cpu1), .aux(aux1), .mem(mb1), .busy(busy1));

  // Synchronous memories: write at posedge, registered read.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] rd0 = '0;
  logic [DW-1:0] rd1 = '0;
  always @(posedge clk) if (mb0.en) begin
    if (mb0.we) mem0[mb0.addr] <= mb0.wdata;
    else        rd0 <= mem0[mb0.addr];
  end
  always @(posedge clk) if (mb1.en) begin
    if (mb1.we) mem1[mb1.addr] <= mb1.wdata;
    else        rd1 <= mem1[mb1.addr];
  end
  assign mb0.rdata = rd0;
  assign mb1.rdata = rd1;

  int total = 0;
  int bad = 0;

  exp_t e_cur;
  exp_t e_n1;
  int   skip;
  logic last;
  logic [DW-1:0] mdl_mem [256];
  bit   mdl_known [256];

  bit cpu_p, aux_p, aux_pulse, persist, rnd, log_gnt;
  logic cpu_we_v, aux_we_v;
  logic [AW-1:0] cpu_addr_v, aux_addr_v;
  logic [DW-1:0] cpu_wd_v, aux_wd_v;
  int gq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("cpu_gnt", cpu0.gnt, e_cur.gc);
    chk("aux_gnt", aux0.gnt, e_cur.ga);
    chk("cpu_rvalid", cpu0.rvalid, e_cur.rvc);
    chk("aux_rvalid", aux0.rvalid, e_cur.rva);
    chk("mem_en", mb0.en, e_cur.en);
    chk("mem_we", mb0.we, e_cur.en & e_cur.we);
    chk("busy", busy0, e_cur.en | e_cur.rvc | e_cur.rva);
    if (e_cur.en) begin
      chk("mem_addr", mb0.addr, e_cur.addr);
      chk("mem_wdata", mb0.wdata, e_cur.wdata);
    end
    if (!(e_cur.rvc && !e_cur.known)) chk("cpu_rdata", cpu0.rdata, e_cur.rvc ? e_cur.rdata : '0);
    if (!(e_cur.rva && !e_cur.known)) chk("aux_rdata", aux0.rdata, e_cur.rva ? e_cur.rdata : '0);
    if (log_gnt) begin
      if (cpu0.gnt) gq.push_back(0);
      if (aux0.gnt) gq.push_back(1);
    end
  endtask

  task automatic drive();
    cpu0.req   = cpu_p;
    cpu0.we    = cpu_we_v;
    cpu0.addr  = cpu_addr_v;
    cpu0.wdata = cpu_wd_v;
    aux0.req   = aux_p | aux_pulse;
    aux0.we    = aux_we_v;
    aux0.addr  = aux_addr_v;
    aux0.wdata = aux_wd_v;
  endtask

  // Transaction view: a granted write occupies the port for 2 cycles, a read
  // for 3 (sample cycle included); conflicts alternate starting with cpu.
  task automatic model_edge();
    logic rc, ra, w;
    rc = cpu0.req;
    ra = aux0.req;
    e_cur = e_n1;
    e_n1  = '0;
    if (skip > 0) skip--;
    else if (rc || ra) begin
      if (rc && ra) w = (last == OWN_AUX) ? OWN_CPU : OWN_AUX;
      else          w = rc ? OWN_CPU : OWN_AUX;
      last = w;
      e_cur.gc    = (w == OWN_CPU);
      e_cur.ga    = (w == OWN_AUX);
      e_cur.en    = 1'b1;
      e_cur.we    = (w == OWN_CPU) ? cpu0.we : aux0.we;
      e_cur.addr  = (w == OWN_CPU) ? cpu0.addr : aux0.addr;
      e_cur.wdata = (w == OWN_CPU) ? cpu0.wdata : aux0.wdata;
      if (e_cur.we) begin
        mdl_mem[e_cur.addr]   = e_cur.wdata;
        mdl_known[e_cur.addr] = 1'b1;
        skip = 1;
      end else begin
        e_n1.rvc   = (w == OWN_CPU);
        e_n1.rva   = (w == OWN_AUX);
        e_n1.rdata = mdl_mem[e_cur.addr];
        e_n1.known = mdl_known[e_cur.addr];
        skip = 2;
      end
    end
  endtask

  task automatic model_reset();
    e_cur = '0;
    e_n1  = '0;
    skip  = 0;
    last  = OWN_AUX;
  endtask

  task automatic step();
    check_outputs();
    if (e_cur.gc && !persist) cpu_p = 1'b0;
    if (e_cur.ga && !persist) aux_p = 1'b0;
    if (rnd) begin
      if (!cpu_p && $urandom_range(0, 1) == 1) begin
        cpu_p = 1'b1;
        cpu_we_v = 1'($urandom_range(0, 1));
        cpu_addr_v = AW'($urandom_range(0, 15));
        cpu_wd_v = DW'($urandom);
      end
      if (!aux_p && $urandom_range(0, 1) == 1) begin
        aux_p = 1'b1;
        aux_we_v = 1'($urandom_range(0, 1));
        aux_addr_v = AW'($urandom_range(0, 15));
        aux_wd_v = DW'($urandom);
      end
    end
    drive();
    model_edge();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((cpu_p || aux_p || skip > 0 || e_cur.en || e_cur.rvc || e_cur.rva) && n < 30) begin
      step();
      n++;
    end
    step();
    chk({tag, "_drain"}, (n < 30), 1);
  endtask

  task automatic set_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_p = 1'b1; cpu_we_v = we; cpu_addr_v = a; cpu_wd_v = d;
  endtask

  task automatic set_aux(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    aux_p = 1'b1; aux_we_v = we; aux_addr_v = a; aux_wd_v = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    cpu_p = 0; aux_p = 0; aux_pulse = 0; persist = 0; rnd = 0; log_gnt = 0;
    cpu_we_v = 0; cpu_addr_v = '0; cpu_wd_v = '0;
    aux_we_v = 0; aux_addr_v = '0; aux_wd_v = '0;
    for (int i = 0; i < 256; i++) begin mdl_mem[i] = '0; mdl_known[i] = 1'b0; end
    cpu1.req = 0; cpu1.we = 0; cpu1.addr = '0; cpu1.wdata = '0;
    aux1.req = 0; aux1.we = 0; aux1.addr = '0; aux1.wdata = '0;
    model_reset();

    // Held in reset with a cpu request pending: everything quiet.
    set_cpu(1'b1, 8'h03, 16'hBEEF);
    drive();
    repeat (3) @(negedge clk);
    check_outputs();
    chk("rst_mem_addr", mb0.addr, 0);
    chk("rst_mem_wdata", mb0.wdata, 0);
    chk("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    drain("wr_beef");

    set_cpu(1'b0, 8'h03, 16'h0000);
    drain("raw");

    // Continuous conflict: grants must alternate.
    log_gnt = 1; persist = 1;
    set_cpu(1'b0, 8'h01, 16'h0000);
    set_aux(1'b1, 8'h02, 16'h1234);
    repeat (14) step();
    persist = 0;
    drain("rr");
    log_gnt = 0;
    chk("rr_count", (gq.size() >= 4), 1);
    for (int i = 1; i < gq.size(); i++) chk("rr_alternate", (gq[i] != gq[i-1]), 1);

    // Reset during the RESP cycle of an aux read.
    set_aux(1'b0, 8'h02, 16'h0000);
    n = 0;
    while (!e_cur.rva && n < 10) begin step(); n++; end
    chk("midrd_reach", e_cur.rva, 1);
    chk("midrd_rvalid_pre", aux0.rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrd_rvalid", aux0.rvalid, 0);
    chk("midrd_rdata", aux0.rdata, 0);
    chk("midrd_busy", busy0, 0);
    model_reset();
    cpu_p = 0; aux_p = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    set_cpu(1'b0, 8'h02, 16'h0000);
    drain("post_rst_rd");

    // aux_req pulsed only while the cpu write is in ISSUE.
    set_cpu(1'b1, 8'h05, 16'h5555);
    n = 0;
    while (!e_cur.gc && n < 10) begin step(); n++; end
    chk("ign_reach", e_cur.gc, 1);
    aux_we_v = 1'b1; aux_addr_v = 8'h09; aux_wd_v = 16'h9999;
    aux_pulse = 1;
    step();
    aux_pulse = 0;
    drain("ignore");

    rnd = 1;
    repeat (400) step();
    rnd = 0;
    drain("rand");

    // CPU-priority instance.
    cpu1.req = 1; cpu1.we = 0; cpu1.addr = 8'h00; cpu1.wdata = '0;
    aux1.req = 1; aux1.we = 1; aux1.addr = 8'h07; aux1.wdata = 16'h7777;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      chk("prio_aux_gnt", aux1.gnt, 0);
      if (cpu1.gnt) cnt++;
    end
    chk("prio_cpu_gnts", (cnt >= 4), 1);
    n = 0;
    while (!cpu1.gnt && n < 5) begin @(negedge clk); n++; end
    chk("prio_cpu_gnt_seen", cpu1.gnt, 1);
    cpu1.req = 0;
    n = 0;
    while (busy1 && n < 5) begin @(negedge clk); n++; end
    chk("prio_idle", busy1, 0);
    @(negedge clk);
    chk("prio_aux_after", aux1.gnt, 1);
    aux1.req = 0;
    repeat (4) @(negedge clk);
    chk("prio_end_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
